// File: rtl/sram_bist_fault_logger.sv
// SRAM BIST read-path checker: delays each BIST read request by the SRAM
// read latency, compares it with the returned data, counts mismatches,
// captures the first failing address and logs failing entries in a
// first-word-fall-through circular buffer.
module sram_bist_fault_logger #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 3,
    parameter int LOG_DEPTH    = 8,
    parameter int CNT_W        = 16,
    localparam int PTR_W       = $clog2(LOG_DEPTH),
    localparam int LCNT_W      = $clog2(LOG_DEPTH + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Arm,
    input  logic              Stop,
    input  logic              Req_valid,
    input  logic [ADDR_W-1:0] Req_address,
    input  logic [DATA_W-1:0] Req_expected,
    input  logic [DATA_W-1:0] Read_data,
    input  logic              Log_rd_en,
    output logic              Log_rd_valid,
    output logic [ADDR_W-1:0] Log_rd_address,
    output logic [DATA_W-1:0] Log_rd_expected,
    output logic [DATA_W-1:0] Log_rd_actual,
    output logic [LCNT_W-1:0] Log_count,
    output logic              Log_overflow,
    output logic [CNT_W-1:0]  Mismatch_total,
    output logic              First_fail_valid,
    output logic [ADDR_W-1:0] First_fail_address,
    output logic              Pending,
    output logic              Done
);

    localparam int LAST = READ_LATENCY - 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DRAIN, ST_DONE} state_t;

    state_t state;

    // Delay line: index 0 is the first stage after acceptance, LAST is the compare stage
    logic              vld_p  [READ_LATENCY];
    logic [ADDR_W-1:0] addr_p [READ_LATENCY];
    logic [DATA_W-1:0] exp_p  [READ_LATENCY];

    logic [ADDR_W-1:0] log_addr [LOG_DEPTH];
    logic [DATA_W-1:0] log_exp  [LOG_DEPTH];
    logic [DATA_W-1:0] log_act  [LOG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic accept;
    logic pending_c;
    logic mismatch;
    logic log_full;
    logic pop;
    logic push_ok;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Arm wins over Stop and Req_valid; a request alongside Stop is refused
    assign accept   = (state == ST_ARMED) && Req_valid && !Arm && !Stop;
    assign mismatch = vld_p[LAST] && (Read_data != exp_p[LAST]);
    assign log_full = (Log_count == LCNT_W'(LOG_DEPTH));
    assign pop      = Log_rd_en && (Log_count != '0);
    // When full, a same-cycle pop frees the slot the new entry takes
    assign push_ok  = mismatch && (!log_full || pop);

    // Any stage holding a valid request means a compare is still in flight
    always_comb begin
        pending_c = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) pending_c = pending_c | vld_p[i];
    end

    assign Pending         = pending_c;
    assign Log_rd_valid    = (Log_count != '0);
    assign Log_rd_address  = log_addr[rd_ptr];
    assign Log_rd_expected = log_exp[rd_ptr];
    assign Log_rd_actual   = log_act[rd_ptr];

    // Control FSM with registered Done flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            Done  <= 1'b0;
        end else if (Arm) begin
            state <= ST_ARMED;
            Done  <= 1'b0;
        end else begin
            case (state)
                ST_ARMED: if (Stop) state <= ST_DRAIN;
                ST_DRAIN: if (!pending_c) begin
                    state <= ST_DONE;
                    Done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---- stage boundary: request -> delay line ----
    // Valid bits; Arm discards everything in flight
    always_ff @(posedge Clock) begin
        if (Reset || Arm) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Request payload travels beside its valid bit, no reset needed
    always_ff @(posedge Clock) begin
        addr_p[0] <= Req_address;
        exp_p[0]  <= Req_expected;
        for (int i = 1; i < READ_LATENCY; i++) begin
            addr_p[i] <= addr_p[i-1];
            exp_p[i]  <= exp_p[i-1];
        end
    end

    // ---- stage boundary: compare -> result registers ----
    // Mismatch counter, first-fail capture and log bookkeeping
    always_ff @(posedge Clock) begin
        if (Reset || Arm) begin
            Mismatch_total     <= '0;
            First_fail_valid   <= 1'b0;
            First_fail_address <= '0;
            Log_overflow       <= 1'b0;
            Log_count          <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
        end else begin
            if (mismatch) Mismatch_total <= sat_inc(Mismatch_total);
            if (mismatch && !First_fail_valid) begin
                First_fail_valid   <= 1'b1;
                First_fail_address <= addr_p[LAST];
            end
            if (mismatch && log_full && !pop) Log_overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            Log_count <= Log_count + LCNT_W'(push_ok) - LCNT_W'(pop);
        end
    end

    // Log storage; cleared on Reset so head outputs start at zero
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < LOG_DEPTH; i++) begin
                log_addr[i] <= '0;
                log_exp[i]  <= '0;
                log_act[i]  <= '0;
            end
        end else if (push_ok && !Arm) begin
            log_addr[wr_ptr] <= addr_p[LAST];
            log_exp[wr_ptr]  <= exp_p[LAST];
            log_act[wr_ptr]  <= Read_data;
        end
    end

endmodule

// File: tb/tb_sram_bist_fault_logger.sv
// Directed bench for sram_bist_fault_logger: default instance plus a
// CNT_W=4 instance sharing the same stimulus to exercise saturation.
module tb_sram_bist_fault_logger;

    logic        Clock = 1'b0;
    logic        Reset, Arm, Stop, Req_valid, Log_rd_en;
    logic [17:0] Req_address;
    logic [15:0] Req_expected;
    logic [15:0] Read_data;
    logic [15:0] act_in, act_d0, act_d1, act_d2;

    logic        Log_rd_valid, Log_overflow, First_fail_valid, Pending, Done;
    logic [17:0] Log_rd_address, First_fail_address;
    logic [15:0] Log_rd_expected, Log_rd_actual, Mismatch_total;
    logic [3:0]  Log_count;

    logic        s_rd_valid, s_overflow, s_ff_valid, s_pending, s_done;
    logic [17:0] s_rd_address, s_ff_address;
    logic [15:0] s_rd_expected, s_rd_actual;
    logic [3:0]  s_total;
    logic [3:0]  s_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 Clock = ~Clock;

    // SRAM stand-in: the data chosen at request time returns three cycles later
    always @(posedge Clock) begin
        act_d0 <= act_in;
        act_d1 <= act_d0;
        act_d2 <= act_d1;
    end
    assign Read_data = act_d2;

    sram_bist_fault_logger dut (
        .Clock(Clock), .Reset(Reset), .Arm(Arm), .Stop(Stop),
        .Req_valid(Req_valid), .Req_address(Req_address), .Req_expected(Req_expected),
        .Read_data(Read_data), .Log_rd_en(Log_rd_en),
        .Log_rd_valid(Log_rd_valid), .Log_rd_address(Log_rd_address),
        .Log_rd_expected(Log_rd_expected), .Log_rd_actual(Log_rd_actual),
        .Log_count(Log_count), .Log_overflow(Log_overflow),
        .Mismatch_total(Mismatch_total), .First_fail_valid(First_fail_valid),
        .First_fail_address(First_fail_address), .Pending(Pending), .Done(Done)
    );

    sram_bist_fault_logger #(.CNT_W(4)) dut_small (
        .Clock(Clock), .Reset(Reset), .Arm(Arm), .Stop(Stop),
        .Req_valid(Req_valid), .Req_address(Req_address), .Req_expected(Req_expected),
        .Read_data(Read_data), .Log_rd_en(Log_rd_en),
        .Log_rd_valid(s_rd_valid), .Log_rd_address(s_rd_address),
        .Log_rd_expected(s_rd_expected), .Log_rd_actual(s_rd_actual),
        .Log_count(s_count), .Log_overflow(s_overflow),
        .Mismatch_total(s_total), .First_fail_valid(s_ff_valid),
        .First_fail_address(s_ff_address), .Pending(s_pending), .Done(s_done)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [17:0] a, input logic [15:0] e, input logic [15:0] d);
        Req_valid    = 1'b1;
        Req_address  = a;
        Req_expected = e;
        act_in       = d;
        tick();
        Req_valid    = 1'b0;
    endtask

    task automatic arm();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
    endtask

    task automatic pop();
        Log_rd_en = 1'b1;
        tick();
        Log_rd_en = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Arm = 1'b0; Stop = 1'b0; Req_valid = 1'b0; Log_rd_en = 1'b0;
        Req_address = '0; Req_expected = '0; act_in = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_rd_valid", Log_rd_valid, 0);
        chk("rst_count", Log_count, 0);
        chk("rst_overflow", Log_overflow, 0);
        chk("rst_total", Mismatch_total, 0);
        chk("rst_ff_valid", First_fail_valid, 0);
        chk("rst_ff_addr", First_fail_address, 0);
        chk("rst_head_addr", Log_rd_address, 0);
        chk("rst_pending", Pending, 0);
        chk("rst_done", Done, 0);
        Reset = 1'b0;
        tick();

        // Test 1: four matching reads, then Stop and drain
        arm();
        for (int i = 0; i < 4; i++) issue(18'(i), 16'h1234, 16'h1234);
        chk("t1_pending", Pending, 1);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        for (int k = 0; k < 4 && Done !== 1'b1; k++) tick();
        chk("t1_done", Done, 1);
        chk("t1_total", Mismatch_total, 0);
        chk("t1_rd_valid", Log_rd_valid, 0);
        chk("t1_ff_valid", First_fail_valid, 0);
        chk("t1_pending", Pending, 0);

        // Test 2: single mismatch, result one cycle after compare
        arm();
        chk("t2_done_cleared", Done, 0);
        issue(18'h00005, 16'hA5A5, 16'h25A5);
        repeat (2) tick();
        chk("t2_total_early", Mismatch_total, 0);
        tick();
        chk("t2_total", Mismatch_total, 1);
        chk("t2_ff_valid", First_fail_valid, 1);
        chk("t2_ff_addr", First_fail_address, 32'h5);
        chk("t2_rd_valid", Log_rd_valid, 1);
        chk("t2_count", Log_count, 1);
        chk("t2_head_addr", Log_rd_address, 32'h5);
        chk("t2_head_exp", Log_rd_expected, 32'hA5A5);
        chk("t2_head_act", Log_rd_actual, 32'h25A5);
        pop();
        chk("t2_count_after_pop", Log_count, 0);
        chk("t2_rd_valid_after_pop", Log_rd_valid, 0);
        pop();
        chk("t2_pop_empty_ignored", Log_count, 0);

        // Test 3: ten mismatches with no pops overflow the log
        arm();
        for (int i = 0; i < 10; i++) issue(18'h10 + 18'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i));
        repeat (3) tick();
        chk("t3_count", Log_count, 8);
        chk("t3_overflow", Log_overflow, 1);
        chk("t3_total", Mismatch_total, 10);
        chk("t3_ff_addr", First_fail_address, 32'h10);
        for (int i = 0; i < 8; i++) begin
            chk("t3_head_addr", Log_rd_address, 32'h10 + i);
            chk("t3_head_exp", Log_rd_expected, 32'h1000 + i);
            chk("t3_head_act", Log_rd_actual, 32'h2000 + i);
            pop();
        end
        chk("t3_empty", Log_rd_valid, 0);
        chk("t3_overflow_sticky", Log_overflow, 1);

        // Test 4: ninth mismatch lands in the same cycle as a pop on a full log
        arm();
        chk("t4_overflow_cleared", Log_overflow, 0);
        for (int i = 0; i < 9; i++) issue(18'h20 + 18'(i), 16'h3000 + 16'(i), 16'h0000);
        repeat (2) tick();
        chk("t4_full_before", Log_count, 8);
        pop();
        chk("t4_count", Log_count, 8);
        chk("t4_overflow", Log_overflow, 0);
        chk("t4_total", Mismatch_total, 9);
        for (int i = 0; i < 8; i++) begin
            chk("t4_head_addr", Log_rd_address, 32'h21 + i);
            chk("t4_head_exp", Log_rd_expected, 32'h3001 + i);
            pop();
        end
        chk("t4_empty", Log_count, 0);

        // Test 5: Arm while mismatches are in flight discards them
        arm();
        issue(18'h40, 16'h0001, 16'h0002);
        issue(18'h41, 16'h0001, 16'h0002);
        arm();
        chk("t5_pending_now", Pending, 0);
        repeat (4) tick();
        chk("t5_total", Mismatch_total, 0);
        chk("t5_count", Log_count, 0);
        chk("t5_pending", Pending, 0);
        chk("t5_ff_valid", First_fail_valid, 0);
        chk("t5_done", Done, 0);
        issue(18'h42, 16'h0005, 16'h0006);
        chk("t5_armed_pending", Pending, 1);
        repeat (3) tick();
        chk("t5_armed_total", Mismatch_total, 1);
        chk("t5_armed_ff_addr", First_fail_address, 32'h42);

        // Test 6: saturation on the narrow counter, requests ignored outside ARMED
        arm();
        for (int i = 0; i < 20; i++) issue(18'h100 + 18'(i), 16'hFFFF, 16'h0000);
        repeat (3) tick();
        chk("t6_total", Mismatch_total, 20);
        chk("t6_small_total", s_total, 15);
        chk("t6_overflow", Log_overflow, 1);
        chk("t6_count", Log_count, 8);
        Req_valid = 1'b1; Req_address = 18'h200; Req_expected = 16'hFFFF; act_in = 16'h0000;
        Stop = 1'b1;
        tick();
        Stop = 1'b0; Req_valid = 1'b0;
        for (int k = 0; k < 8 && Done !== 1'b1; k++) tick();
        chk("t6_done", Done, 1);
        chk("t6_stop_req_dropped", Mismatch_total, 20);
        issue(18'h201, 16'hFFFF, 16'h0000);
        repeat (4) tick();
        chk("t6_done_total", Mismatch_total, 20);
        chk("t6_done_small_total", s_total, 15);
        chk("t6_done_pending", Pending, 0);
        chk("t6_done_hold", Done, 1);
        chk("t6_done_head", Log_rd_address, 32'h100);
        pop();
        chk("t6_done_pop", Log_count, 7);
        chk("t6_done_head_next", Log_rd_address, 32'h101);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_bist_fault_logger.md
Name: sram_bist_fault_logger

Overview:
Downstream checker and logger for the SRAM BIST read path. It takes each BIST read request (address plus expected data) and delays it by the SRAM controller's read latency. It then compares the delayed request against the returned SRAM read data. Mismatches are counted, the first failure is captured, and up to LOG_DEPTH failing entries are stored in a first-word-fall-through log for readout to LEDs or a debug port.

Parameters:
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width
READ_LATENCY, 3, cycles from request to valid Read_data (legal 1..4)
LOG_DEPTH, 8, failure log entries (power of 2, >=2)
CNT_W, 16, width of saturating mismatch counter

Ports:
Clock  in  1  system clock, all logic rising-edge
Reset  in  1  synchronous, active-high reset
Arm  in  1  pulse: clear all results, enter ARMED
Stop  in  1  pulse: end of test, drain in-flight compares
Req_valid  in  1  BIST issues a read this cycle
Req_address  in  ADDR_W  address of the read
Req_expected  in  DATA_W  expected data for the read
Read_data  in  DATA_W  SRAM read data, valid READ_LATENCY cycles after request
Log_rd_en  in  1  pop head of log
Log_rd_valid  out  1  log non-empty, head outputs valid
Log_rd_address  out  ADDR_W  head entry address
Log_rd_expected  out  DATA_W  head entry expected data
Log_rd_actual  out  DATA_W  head entry read data
Log_count  out  clog2(LOG_DEPTH+1)  entries stored
Log_overflow  out  1  sticky: a mismatch was dropped because the log was full
Mismatch_total  out  CNT_W  saturating mismatch count
First_fail_valid  out  1  first failure captured
First_fail_address  out  ADDR_W  address of first failure
Pending  out  1  any compare in flight
Done  out  1  state DONE

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0.
  - Pipeline valid bits 0, log empty.
- State machine:
  - States are IDLE, ARMED, DRAIN, DONE.
  - Arm in any state: synchronous clear of log, Log_overflow, Mismatch_total, First_fail_* and all pipeline valid bits (in-flight compares discarded); next state ARMED.
  - Arm has priority over Stop and Req_valid in the same cycle.
  - ARMED + Stop -> DRAIN. A Req_valid in the same cycle as Stop is not accepted.
  - DRAIN -> DONE on the first cycle Pending=0.
  - DONE holds until Arm or Reset. Stop in IDLE/DONE is ignored.
- Request acceptance: only in ARMED. Req_valid in IDLE, DRAIN or DONE is ignored.
- Delay pipeline:
  - READ_LATENCY register stages carry {valid, address, expected}.
  - An accepted request at cycle t reaches the compare stage at cycle t+READ_LATENCY and is compared with Read_data sampled in that cycle.
  - Pending = OR of all stage valid bits.
- Compare: mismatch = stage valid && (Read_data != expected), full-width compare. Result effects (counter, first-fail, log push) are registered and visible at t+READ_LATENCY+1.
- Mismatch_total: +1 per mismatch, saturates at 2^CNT_W-1, never wraps.
- First fail: on the first mismatch after Reset/Arm, First_fail_valid=1 and First_fail_address latched. Both hold until the next Arm/Reset.
- Log:
  - Circular buffer of {address, expected, actual}, FIFO order.
  - First-word-fall-through: Log_rd_valid = Log_count!=0, and head fields are valid whenever Log_rd_valid=1.
  - Log_rd_en pops only when Log_rd_valid=1; otherwise ignored.
  - Push on mismatch when not full, or when full and a pop occurs the same cycle (count unchanged, no overflow).
  - Push when full without a pop: entry dropped, Log_overflow set (sticky). Counter and first-fail still update.
  - Push and pop with count=1: head replaced, count stays 1.
  - Read and write pointers wrap modulo LOG_DEPTH.
  - Log readout is permitted in every state, including DONE.
- Head outputs when empty: hold last value (don't care).

Test Plan:
1. Reset, Arm, 4 reads addr 0..3 exp 0x1234, Read_data 0x1234 at +3, Stop -> Mismatch_total=0, Log_rd_valid=0, First_fail_valid=0; Done=1 by 4 cycles after Stop.
2. Arm, read addr 0x00005 exp 0xA5A5, Read_data 0x25A5 three cycles later -> next cycle Mismatch_total=1, First_fail_address=0x00005, Log_rd_valid=1 head {0x00005,0xA5A5,0x25A5}; pulse Log_rd_en -> Log_count=0.
3. 10 back-to-back mismatching reads addr 0x10..0x19, no pops -> Log_count=8, Log_overflow=1, Mismatch_total=10; popping yields 0x10..0x17 in order; First_fail_address=0x10.
4. Fill log with 8 mismatches, 9th mismatch result arrives same cycle as Log_rd_en -> Log_count=8, Log_overflow=0, head advances by one, tail holds 9th entry.
5. Arm, issue 2 mismatching reads, assert Arm again 1 cycle later -> in-flight compares discarded: Mismatch_total=0, Log_count=0, Pending=0, state ARMED.
6. CNT_W=4: 20 mismatches -> Mismatch_total=15 (saturated); Req_valid while DONE -> no counter change.
